// File: rtl/filter_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : filter_ctrl_pkg
// Purpose  : Shared definitions for the 3x3 filter sequencing controller.
//            Holds the controller state encoding, the filter mode constants
//            and the default frame geometry / datapath latency.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package filter_ctrl_pkg;

    // Frame geometry: OUT_LENGTH windows need OUT_LENGTH + 2 padded columns.
    localparam int DEF_OUT_LENGTH  = 100;
    localparam int DEF_DATA_LENGTH = DEF_OUT_LENGTH + 2;
    // Cycles from calc_en to a valid result in the filter datapath (1..4).
    localparam int DEF_PIPE_LAT    = 2;

    // Filter selection carried on mode / mode_q.
    localparam logic MODE_MEDIAN = 1'b0;
    localparam logic MODE_MEAN   = 1'b1;

    // Controller states, explicitly encoded.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage : filter_ctrl_pkg
`default_nettype wire

// File: rtl/valid_delay_line.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : valid_delay_line
// Purpose  : DEPTH-deep 1-bit shift register that delays the compute strobe
//            by the datapath latency, with an "empty" flag that reports that
//            no strobe is still in flight.
// Ports    : clk      - clock, rising edge
//            reset    - asynchronous active-high reset, clears all stages
//            i_valid  - strobe entering the delay line
//            o_valid  - strobe delayed by exactly DEPTH cycles
//            o_empty  - high when no stage holds a strobe
// Revision : 1.0 - initial release
// ============================================================================
module valid_delay_line
    import filter_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_PIPE_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_valid,
    output logic o_valid,
    output logic o_empty
);

    logic [DEPTH-1:0] r_stages;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_stages <= '0;
                end else begin
                    r_stages <= i_valid;
                end
            end
        end else begin : g_multi
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_stages <= '0;
                end else begin
                    r_stages <= {r_stages[DEPTH-2:0], i_valid};
                end
            end
        end
    endgenerate

    assign o_valid = r_stages[DEPTH-1];
    assign o_empty = ~|r_stages;

endmodule : valid_delay_line
`default_nettype wire

// File: rtl/filter_seq_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : filter_seq_ctrl
// Purpose  : Sequencing controller for a streaming 3x3 median/mean filter.
//            Accepts DATA_LENGTH padded columns per frame, raises calc_en
//            once per complete window (OUT_LENGTH per frame) and tracks the
//            datapath latency so that out_valid and done line up with the
//            last filtered pixel.
// Ports    : clk       - clock, rising edge
//            reset     - asynchronous active-high reset
//            start     - frame start request, sampled only while idle
//            mode      - filter select (0 median, 1 mean), latched on start
//            in_valid  - a 3-pixel column is present this cycle
//            in_ready  - controller accepts a column this cycle
//            shift_en  - shift the window registers (in_valid & in_ready)
//            calc_en   - window complete, datapath computes this cycle
//            out_valid - datapath result valid this cycle
//            mode_q    - latched filter mode for the datapath
//            col_cnt   - columns accepted in the current frame
//            busy      - controller is not idle
//            done      - one-cycle end-of-frame pulse
// Revision : 1.0 - initial release
// ============================================================================
module filter_seq_ctrl
    import filter_ctrl_pkg::*;
#(
    parameter int DATA_LENGTH = DEF_DATA_LENGTH,
    parameter int OUT_LENGTH  = DEF_OUT_LENGTH,
    parameter int PIPE_LAT    = DEF_PIPE_LAT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           mode,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           shift_en,
    output logic                           calc_en,
    output logic                           out_valid,
    output logic                           mode_q,
    output logic [$clog2(DATA_LENGTH)-1:0] col_cnt,
    output logic                           busy,
    output logic                           done
);

    localparam int CNT_W = $clog2(DATA_LENGTH);

    // The first two columns only prime the window; every later column
    // completes one window, so the last column index is OUT_LENGTH + 1.
    localparam logic [CNT_W-1:0] c_FILL_LAST = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_LAST_COL  = CNT_W'(OUT_LENGTH + 1);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_calc_en;
    logic   w_dl_empty;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid && (col_cnt == c_FILL_LAST)) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                if (in_valid && (col_cnt == c_LAST_COL)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave only once the final calc_en has entered the delay
                // line and worked its way out of it.
                if (!r_calc_en && w_dl_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign shift_en = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Column counter, latched mode and registered compute strobe
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt   <= '0;
            mode_q    <= MODE_MEDIAN;
            r_calc_en <= 1'b0;
        end else begin
            r_calc_en <= shift_en && (r_state == S_RUN);
            if ((r_state == S_IDLE) && start) begin
                col_cnt <= '0;
                mode_q  <= mode;
            end else if (shift_en && (col_cnt != c_LAST_COL)) begin
                // The final column does not advance the count, so it holds
                // at DATA_LENGTH-1 through DRAIN and DONE.
                col_cnt <= col_cnt + 1'b1;
            end else if (r_state == S_DONE) begin
                col_cnt <= '0;
            end
        end
    end

    assign calc_en = r_calc_en;

    valid_delay_line #(
        .DEPTH (PIPE_LAT)
    ) u_valid_delay_line (
        .clk     (clk),
        .reset   (reset),
        .i_valid (r_calc_en),
        .o_valid (out_valid),
        .o_empty (w_dl_empty)
    );

endmodule : filter_seq_ctrl
`default_nettype wire

// File: doc/filter_seq_ctrl.md
FILTER_SEQ_CTRL -- requirements
Module: filter_seq_ctrl

Interface
REQ-001 Parameter: DATA_LENGTH, 102, padded columns per frame (OUT_LENGTH + 2).
REQ-002 Parameter: OUT_LENGTH, 100, windows/output pixels per frame.
REQ-003 Parameter: PIPE_LAT, 2, cycles from calc_en to valid result in the filter datapath (range 1..4).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: start  input  1  frame start request; sampled only in IDLE.
REQ-007 Port: mode  input  1  filter select (0 = median, 1 = mean); latched on accepted start.
REQ-008 Port: in_valid  input  1  a 3-pixel column (pixel_in0..2) is present this cycle.
REQ-009 Port: in_ready  output  1  controller accepts a column this cycle.
REQ-010 Port: shift_en  output  1  shift the 3x3 window registers; equals in_valid & in_ready.
REQ-011 Port: calc_en  output  1  window is complete; datapath computes this cycle.
REQ-012 Port: out_valid  output  1  datapath pixel_out is valid this cycle.
REQ-013 Port: mode_q  output  1  latched mode driven to the datapath.
REQ-014 Port: col_cnt  output  $clog2(DATA_LENGTH)  columns accepted in current frame.
REQ-015 Port: busy  output  1  high in every state except IDLE.
REQ-016 Port: done  output  1  one-cycle pulse at end of frame.

Function
REQ-017 States SHALL be IDLE, FILL, RUN, DRAIN, DONE.
REQ-018 IDLE: in_ready=0; start=1 -> FILL, col_cnt<=0, mode_q<=mode.
REQ-019 FILL: in_ready=1; each accept increments col_cnt; accept of column 1 -> RUN.
REQ-020 RUN: in_ready=1; each accept increments col_cnt and sets calc_en=1 in the following cycle (registered).
REQ-021 RUN: accept of column DATA_LENGTH-1 -> DRAIN; in_ready=0 from the next cycle.
REQ-022 in_valid=0 in FILL/RUN SHALL be a stall: no shift, counters and state hold, no calc_en next cycle; gaps of any length allowed.
REQ-023 out_valid SHALL equal calc_en delayed exactly PIPE_LAT cycles: column accepted at cycle t in RUN -> calc_en at t+1 -> out_valid at t+1+PIPE_LAT.
REQ-024 Exactly OUT_LENGTH calc_en and OUT_LENGTH out_valid pulses per frame; exactly DATA_LENGTH shift_en pulses.
REQ-025 DRAIN: holds until the delay line is empty (last out_valid has occurred) -> DONE.
REQ-026 DONE: done=1 for one cycle, busy=1 -> IDLE next cycle.
REQ-027 start outside IDLE SHALL be ignored; mode changes outside IDLE SHALL NOT affect mode_q.
REQ-028 in_valid in IDLE, DRAIN or DONE SHALL be ignored (shift_en=0).
REQ-029 col_cnt SHALL saturate at DATA_LENGTH-1 in DRAIN/DONE and never wrap.

Reset
REQ-030 reset=1 SHALL immediately force IDLE, col_cnt=0, mode_q=0, empty delay line, and all outputs 0 (in_ready, shift_en, calc_en, out_valid, busy, done).
REQ-031 Reset mid-frame SHALL abandon the frame; no done pulse; next start begins a clean frame.

Structure
REQ-032 Shared package filter_ctrl_pkg SHALL hold the state encoding, MODE_MEDIAN/MODE_MEAN constants, and DATA_LENGTH/OUT_LENGTH/PIPE_LAT defaults.
REQ-033 One sub-module valid_delay_line (PIPE_LAT-deep 1-bit shift register with async reset and empty flag) SHALL generate out_valid.

Verification
REQ-034 Reset pulse (2.5 ns high) during RUN at col_cnt=50 -> all outputs 0 within the reset interval, state IDLE, no done.
REQ-035 start with mode=1, 102 back-to-back in_valid -> first calc_en 1 cycle after 3rd accept, first out_valid 3 cycles after it, 100 out_valid, one done, mode_q=1 throughout.
REQ-036 Same frame with in_valid high every other cycle -> 102 shift_en, 100 out_valid, done once, no calc_en after a stall cycle.
REQ-037 start re-asserted and mode toggled during RUN -> ignored; frame count and mode_q unchanged.
REQ-038 in_valid=1 for 10 cycles in IDLE -> shift_en=0, col_cnt=0, busy=0.
REQ-039 Two consecutive frames, start asserted in the cycle after done -> second frame accepted, 200 total out_valid, two done pulses.
